program_sequencer: RTL and testbench
====================================

# program_sequencer

Instruction source for the accumulator core, sitting directly upstream of its 11-bit instruction input. It holds a small program memory that the operator loads word-by-word from the switches, then replays one word per fetch/decode/execute round. Program-counter advance is keyed to the core's fetch strobe. After the last stored word it holds a no-op and flags halt.

## Interface
- DEPTH, 16, program memory words
- AW, 4, address/PC width (log2 DEPTH)
- IW, 11, instruction width (opcode [10:8], literal [7:0])
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- sw_in  in  IW  instruction word from switches
- wr_btn  in  1  write button level, assumed already debounced; block edge-detects it
- run  in  1  level: 0 = load mode, 1 = run mode
- fetch  in  1  core fetch strobe (f), high for exactly the fetch cycle
- instr_out  out  IW  to core `in`
- pc  out  AW  current program counter
- halted  out  1  high in HALT
- loading  out  1  high in LOAD

## Operation
- Reset values: state LOAD, pc 0, len 0, wr_q 0, fetch_q 0, instr_out NOP, halted 0, loading 1. Memory contents are not cleared.
- NOP is 11'h2FF (opcode 010 AND, literal FF), which leaves the accumulator unchanged.
- len: count of valid words, 0..DEPTH, width AW+1.
- LOAD:
  - A write pulse is wr_btn=1 and wr_q=0.
  - On a write pulse: mem[pc] <= sw_in, pc <= pc+1 (mod DEPTH, wraps 15->0), len <= max(len, pc+1).
  - instr_out = NOP.
  - When run=1: go to RUN with pc <= 0 if len>0, otherwise go to HALT.
- RUN:
  - instr_out = mem[pc], combinational from pc.
  - Advance pulse is fetch_q=1 and fetch=0, i.e. the cycle after fetch, when the core decodes.
  - On an advance pulse: if pc == len-1, go to HALT (pc holds); otherwise pc <= pc+1.
  - When run=0: go to LOAD with pc <= 0. Memory and len are preserved.
- HALT:
  - instr_out = NOP, halted = 1.
  - When run=0: go to LOAD with pc <= 0.
- Rerun: toggling run 1->0->1 replays the stored program without reloading.
- Load after reload: writes overwrite from address 0. len only grows, so words beyond the new writes remain part of the program.
- Priority within a cycle: rst > run transition > write/advance pulse. A write pulse coinciding with LOAD->RUN is dropped. An advance pulse coinciding with RUN->LOAD is dropped.
- Writes are ignored outside LOAD. fetch is ignored outside RUN.
- DEPTH+1 writes in one LOAD session wrap and overwrite mem[0]; len saturates at DEPTH.

## Timing
- Write latency: the word is in memory and pc is incremented at the first edge where the pulse condition holds. The button level must drop before another write is accepted.
- Core handoff:
  - The core latches its instruction register at the edge closing its decode cycle.
  - That same edge is where pc advances, so the core captures the old mem[pc].
  - Required: instr_out stable from fetch rising through the end of decode; no glitch at that edge from a pc change.
- Throughput: one instruction per three-cycle core round. The last instruction executes, then HALT asserts at the edge closing the final decode cycle.
- run edges take effect at the next clock edge. No synchronizer is inside the block; run must be pre-synchronized.
- Mid-operation reset: all registers go to their reset values at that edge. instr_out becomes NOP the same cycle (combinational from state).

## Structure
- Shared package holds:
  - state enum {LOAD, RUN, HALT}
  - NOP constant 11'h2FF
  - opcode constants: ADD 000, SUB 001, AND 010, OR 011, PASS 100, SHL 101, SHR 110, XOR 111
  - IW
- One sub-module, edge_detect, instantiated twice (wr_btn, fetch). It is a 1-bit register plus a rising or falling pulse output.
- Memory is an inferred register array inside program_sequencer: synchronous write, asynchronous read.

## Test plan
- Reset then observe idle: loading=1, pc=0, instr_out=0x2FF, halted=0.
- Load 0x405, 0x003, 0x102 with three button presses, assert run, drive fetch pattern f,d,e ×3:
  - instr_out sequence must be 0x405, 0x003, 0x102.
  - halted=1 after the third decode.
  - Core accumulator must end at 0x06.
- Hold wr_btn high 5 cycles: exactly one write, pc=1.
- Press write in the same cycle run rises: no write, state RUN (or HALT if len=0).
- 17 writes: pc wraps to 1, len=16, mem[0] holds the 17th word.
- Assert rst mid-RUN at pc=2: next cycle LOAD, pc=0, len=0, instr_out=0x2FF. Run with len=0 goes directly to HALT.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the accumulator-core program sequencer.
package program_sequencer_pkg;

  localparam int IW = 11;

  // AND with all-ones literal: leaves the accumulator untouched.
  localparam logic [IW-1:0] NOP = 11'h2FF;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/program_sequencer_edge_detect.sv
// One-bit level register with a single-cycle rising or falling edge pulse.
module edge_detect #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_d;
  end

  assign pulse = RISING ? (d & ~d_q) : (d_q & ~d);

endmodule

// File: rtl/program_sequencer.sv
// Switch-loaded program memory replayed into the accumulator core, one word
// per fetch/decode/execute round, holding a no-op once the program ends.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] sw_in,
  input  logic          wr_btn,
  input  logic          run,
  input  logic          fetch,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          loading
);

  localparam logic [AW-1:0] PC_ONE  = 1;
  localparam logic [AW:0]   LEN_ONE = 1;

  logic          wr_pulse;
  logic          adv_pulse;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic          halted_q, halted_d;
  logic          loading_q, loading_d;
  logic          mem_we;
  logic [AW:0]   pc_plus1;

  logic [IW-1:0] mem [DEPTH];

  edge_detect #(.RISING(1'b1)) u_wr_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (wr_btn),
    .pulse (wr_pulse)
  );

  // Falling edge of fetch marks the decode cycle; pc moves at its closing edge.
  edge_detect #(.RISING(1'b0)) u_fetch_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (fetch),
    .pulse (adv_pulse)
  );

  assign pc_plus1 = {1'b0, pc_q} + LEN_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (run) begin
          state_d = (len_q != '0) ? ST_RUN : ST_HALT;
          pc_d    = '0;
        end else if (wr_pulse) begin
          mem_we = 1'b1;
          pc_d   = pc_q + PC_ONE;
          if (pc_plus1 > len_q) len_d = pc_plus1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_LOAD;
          pc_d    = '0;
        end else if (adv_pulse) begin
          if ({1'b0, pc_q} == (len_q - LEN_ONE)) state_d = ST_HALT;
          else                                   pc_d    = pc_q + PC_ONE;
        end
      end
      ST_HALT: begin
        if (!run) begin
          state_d = ST_LOAD;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        pc_d    = '0;
      end
    endcase
    halted_d  = (state_d == ST_HALT);
    loading_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      pc_q      <= '0;
      len_q     <= '0;
      halted_q  <= 1'b0;
      loading_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      halted_q  <= halted_d;
      loading_q <= loading_d;
    end
  end

  // Program memory survives reset; only the write is blocked by it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[pc_q] <= sw_in;
  end

  assign instr_out = (state_q == ST_RUN) ? mem[pc_q] : NOP;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign loading   = loading_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed table, corner-case sequences and
// randomized traffic against a rule-level reference model.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  logic          clk = 1'b0;
  logic          rst, wr_btn, run, fetch;
  logic [IW-1:0] sw_in, instr_out;
  logic [3:0]    pc;
  logic          halted, loading;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .wr_btn    (wr_btn),
    .run       (run),
    .fetch     (fetch),
    .instr_out (instr_out),
    .pc        (pc),
    .halted    (halted),
    .loading   (loading)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = load, 1 = run, 2 = halt.
  int            m_mode = 0;
  int            m_pc = 0;
  int            m_len = 0;
  logic [IW-1:0] m_mem [16];
  bit            m_pw = 0, m_pf = 0;

  task automatic model_edge(input bit r, input bit rn, input bit w, input bit f, input logic [IW-1:0] s);
    bit wp, ap;
    if (r) begin
      m_mode = 0; m_pc = 0; m_len = 0; m_pw = 0; m_pf = 0;
      return;
    end
    wp = w && !m_pw;
    ap = m_pf && !f;
    m_pw = w;
    m_pf = f;
    case (m_mode)
      0: begin
        if (rn) begin
          m_mode = (m_len > 0) ? 1 : 2;
          m_pc   = 0;
        end else if (wp) begin
          m_mem[m_pc] = s;
          if (m_pc + 1 > m_len) m_len = m_pc + 1;
          m_pc = (m_pc + 1) % 16;
        end
      end
      1: begin
        if (!rn) begin
          m_mode = 0; m_pc = 0;
        end else if (ap) begin
          if (m_pc == m_len - 1) m_mode = 2;
          else m_pc = m_pc + 1;
        end
      end
      default: begin
        if (!rn) begin
          m_mode = 0; m_pc = 0;
        end
      end
    endcase
  endtask

  task automatic cyc(input bit r, input bit rn, input bit w, input bit f, input logic [IW-1:0] s);
    logic [IW-1:0] exp_instr;
    rst = r; run = rn; wr_btn = w; fetch = f; sw_in = s;
    @(posedge clk);
    model_edge(r, rn, w, f, s);
    #1;
    exp_instr = (m_mode == 1) ? m_mem[m_pc] : NOP;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("loading", 32'(loading), 32'(m_mode == 0));
    chk("instr_out", 32'(instr_out), 32'(exp_instr));
  endtask

  // One core round: fetch, decode, execute.
  task automatic round();
    cyc(0, 1, 0, 1, '0);
    cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
  endtask

  function automatic logic [7:0] alu(input logic [7:0] acc, input logic [IW-1:0] ins);
    logic [7:0] lit;
    lit = ins[7:0];
    case (ins[10:8])
      OP_ADD:  return acc + lit;
      OP_SUB:  return acc - lit;
      OP_AND:  return acc & lit;
      OP_OR:   return acc | lit;
      OP_PASS: return lit;
      OP_SHL:  return acc << 1;
      OP_SHR:  return acc >> 1;
      default: return acc ^ lit;
    endcase
  endfunction

  typedef struct {
    bit            r, rn, w, f;
    logic [IW-1:0] s;
    int            pc;
    bit            h, l;
    logic [IW-1:0] instr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit rn, input bit w, input bit f, input logic [IW-1:0] s,
                     input int epc, input bit eh, input bit el, input logic [IW-1:0] ei);
    vec_t v;
    v.r = r; v.rn = rn; v.w = w; v.f = f; v.s = s;
    v.pc = epc; v.h = eh; v.l = el; v.instr = ei;
    vt.push_back(v);
  endtask

  initial begin
    logic [7:0]    acc;
    logic [IW-1:0] seen [$];
    bit            rn_r;

    add(1, 0, 0, 0, 11'h000, 0, 0, 1, NOP);
    add(0, 0, 1, 0, 11'h405, 1, 0, 1, NOP);
    add(0, 0, 0, 0, 11'h000, 1, 0, 1, NOP);
    add(0, 0, 1, 0, 11'h003, 2, 0, 1, NOP);
    add(0, 0, 0, 0, 11'h000, 2, 0, 1, NOP);
    add(0, 0, 1, 0, 11'h102, 3, 0, 1, NOP);
    add(0, 0, 0, 0, 11'h000, 3, 0, 1, NOP);
    add(0, 1, 0, 0, 11'h000, 0, 0, 0, 11'h405);
    add(0, 1, 0, 1, 11'h000, 0, 0, 0, 11'h405);
    add(0, 1, 0, 0, 11'h000, 1, 0, 0, 11'h003);
    add(0, 1, 0, 0, 11'h000, 1, 0, 0, 11'h003);
    add(0, 1, 0, 1, 11'h000, 1, 0, 0, 11'h003);
    add(0, 1, 0, 0, 11'h000, 2, 0, 0, 11'h102);
    add(0, 1, 0, 0, 11'h000, 2, 0, 0, 11'h102);
    add(0, 1, 0, 1, 11'h000, 2, 0, 0, 11'h102);
    add(0, 1, 0, 0, 11'h000, 2, 1, 0, NOP);
    add(0, 1, 0, 0, 11'h000, 2, 1, 0, NOP);

    acc = 8'h00;
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].r, vt[i].rn, vt[i].w, vt[i].f, vt[i].s);
      chk("tbl_pc", 32'(pc), 32'(vt[i].pc));
      chk("tbl_halted", 32'(halted), 32'(vt[i].h));
      chk("tbl_loading", 32'(loading), 32'(vt[i].l));
      chk("tbl_instr", 32'(instr_out), 32'(vt[i].instr));
      // Value visible during decode is what the core latches.
      if (vt[i].f) begin
        seen.push_back(instr_out);
        acc = alu(acc, instr_out);
      end
    end
    chk("seq_len", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("seq0", 32'(seen[0]), 32'h405);
      chk("seq1", 32'(seen[1]), 32'h003);
      chk("seq2", 32'(seen[2]), 32'h102);
    end
    chk("acc_final", 32'(acc), 32'h06);

    // Rerun without reloading replays the same three words.
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
    chk("rerun_instr", 32'(instr_out), 32'h405);
    for (int k = 0; k < 3; k++) round();
    chk("rerun_halt", 32'(halted), 32'd1);

    // Held button produces exactly one write.
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 11'h0AA + 11'(k));
    cyc(0, 0, 0, 0, '0);
    chk("hold_pc", 32'(pc), 32'd1);
    cyc(0, 1, 0, 0, '0);
    chk("hold_instr", 32'(instr_out), 32'h0AA);
    round();
    chk("hold_len1_halt", 32'(halted), 32'd1);

    // Write coinciding with run rising is dropped.
    cyc(1, 0, 0, 0, '0);
    cyc(0, 1, 1, 0, 11'h123);
    chk("wrrun_empty_halt", 32'(halted), 32'd1);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 11'h456);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 1, 0, 11'h777);
    chk("wrrun_loading", 32'(loading), 32'd0);
    chk("wrrun_instr", 32'(instr_out), 32'h456);
    round();
    chk("wrrun_len_kept", 32'(halted), 32'd1);

    // Seventeen writes wrap the address and overwrite word 0.
    cyc(0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 17; k++) begin
      cyc(0, 0, 1, 0, 11'h100 + 11'(k));
      cyc(0, 0, 0, 0, '0);
    end
    chk("wrap_pc", 32'(pc), 32'd1);
    cyc(0, 1, 0, 0, '0);
    chk("wrap_mem0", 32'(instr_out), 32'h110);
    for (int k = 0; k < 16; k++) begin
      round();
      chk("wrap_halt", 32'(halted), 32'(k == 15));
    end

    // Reset in the middle of a run clears pc and len but not memory.
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
    round();
    round();
    chk("mid_pc2", 32'(pc), 32'd2);
    cyc(1, 1, 0, 0, '0);
    chk("rst_loading", 32'(loading), 32'd1);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'(NOP));
    chk("rst_halted", 32'(halted), 32'd0);
    cyc(0, 1, 0, 0, '0);
    chk("rst_len0_halt", 32'(halted), 32'd1);

    // Randomized traffic against the model.
    rn_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) rn_r = ~rn_r;
      cyc(($urandom_range(0, 299) == 0), rn_r, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 11'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
